// File: rtl/mul_const_pkg.sv
// Shared constants for the constant-multiply datapath (x * MUL_K as shift-and-subtract).
package mul_const_pkg;
  localparam int MUL_K     = 7;
  localparam int MUL_SHIFT = $clog2(MUL_K + 1);
  localparam int DEF_W     = 20;
  localparam int DEF_SPLIT = 10;

  function automatic int outw(input int w);
    return w + MUL_SHIFT;
  endfunction
endpackage

// File: rtl/split_add_stage.sv
// Registered adder slice: on enable, captures a + b + cin as a sum slice plus carry-out.
module split_add_stage #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (en) begin
      {cout, sum} <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end
  end

endmodule

// File: rtl/mul7_pipe.sv
// Two-stage pipelined x7 multiplier: (in << 3) + ~in + 1, carry split at SPLIT.
// Valid/ready on both sides; in_ready is combinational from out_ready (no skid buffer).
module mul7_pipe
  import mul_const_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int SPLIT = DEF_SPLIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [outw(W)-1:0]  out_data
);

  localparam int OW = outw(W);
  localparam int HW = OW - SPLIT;

  logic          adv1, adv2;
  logic          s1_v, s2_v;
  logic [OW-1:0] op_shl, op_inv;

  logic [SPLIT-1:0] s1_lo;
  logic             s1_c;
  logic [HW-1:0]    s1_a_hi, s1_b_hi;
  logic [SPLIT-1:0] s2_lo;
  logic [HW-1:0]    s2_hi;
  logic             unused_hi_cout;

  assign adv2      = !s2_v || out_ready;
  assign adv1      = !s1_v || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_v;
  assign out_data  = {s2_hi, s2_lo};

  // Subtrahend is the one's complement; the +1 enters as carry-in of the low slice.
  assign op_shl = {in_data, {MUL_SHIFT{1'b0}}};
  assign op_inv = ~{{MUL_SHIFT{1'b0}}, in_data};

  split_add_stage #(.WIDTH(SPLIT)) u_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv1),
    .a     (op_shl[SPLIT-1:0]),
    .b     (op_inv[SPLIT-1:0]),
    .cin   (1'b1),
    .sum   (s1_lo),
    .cout  (s1_c)
  );

  // The final carry-out is the 2^OW wrap of the two's-complement subtract and is dropped.
  split_add_stage #(.WIDTH(HW)) u_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv2),
    .a     (s1_a_hi),
    .b     (s1_b_hi),
    .cin   (s1_c),
    .sum   (s2_hi),
    .cout  (unused_hi_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_a_hi <= '0;
      s1_b_hi <= '0;
      s2_v    <= 1'b0;
      s2_lo   <= '0;
    end else begin
      if (adv1) begin
        s1_v    <= in_valid;
        s1_a_hi <= op_shl[OW-1:SPLIT];
        s1_b_hi <= op_inv[OW-1:SPLIT];
      end
      if (adv2) begin
        s2_v  <= s1_v;
        s2_lo <= s1_lo;
      end
    end
  end

endmodule
